// File: rtl/march_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// march_pkg : shared types and ray-slice field indices for march_scheduler
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package march_pkg;

    localparam int RAY_FIELDS = 9;

    localparam int ORG_X   = 0;
    localparam int ORG_Y   = 1;
    localparam int ORG_Z   = 2;
    localparam int DIR_X   = 3;
    localparam int DIR_Y   = 4;
    localparam int DIR_Z   = 5;
    localparam int LIGHT_X = 6;
    localparam int LIGHT_Y = 7;
    localparam int LIGHT_Z = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/march_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin grant, search begins after `last`
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    input  logic                     en,
    output logic [N_REQ-1:0]         grant
);

    localparam int IW = $clog2(N_REQ);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(last) + k) % N_REQ);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/march_scheduler.sv
// ---------------------------------------------------------------------------
// march_scheduler : round-robin sharing of one ray/sphere marcher among requesters
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module march_scheduler
    import march_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int W            = 16,
    parameter int MARCH_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*RAY_FIELDS*W-1:0] req_ray,
    output logic                          m_start,
    output logic [W-1:0]                  m_origin_x,
    output logic [W-1:0]                  m_origin_y,
    output logic [W-1:0]                  m_origin_z,
    output logic [W-1:0]                  m_dir_x,
    output logic [W-1:0]                  m_dir_y,
    output logic [W-1:0]                  m_dir_z,
    output logic [W-1:0]                  m_light_x,
    output logic [W-1:0]                  m_light_y,
    output logic [W-1:0]                  m_light_z,
    input  logic                          m_hit,
    input  logic [W-1:0]                  m_intensity,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(N_REQ)-1:0]      rsp_id,
    output logic                          rsp_hit,
    output logic [W-1:0]                  rsp_intensity
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MARCH_CYCLES + 2);
    localparam int SW = RAY_FIELDS * W;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    ops [RAY_FIELDS];
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic [SW-1:0]   sel_ray;
    logic            arb_en;
    logic            accept;
    logic            capture;
    logic            handshake;

    // Flush gates the grant so nothing is accepted on an aborting edge.
    assign arb_en = (state == IDLE) && !flush;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (req_valid),
        .last  (last),
        .en    (arb_en),
        .grant (grant)
    );

    assign req_ready = grant;

    always_comb begin
        grant_idx = '0;
        sel_ray   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
                sel_ray   = req_ray[i*SW +: SW];
            end
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        capture    = 1'b1;
                        state_next = RESP;
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        handshake  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last          <= IW'(N_REQ - 1);
            cnt           <= '0;
            m_start       <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_hit       <= 1'b0;
            rsp_intensity <= '0;
            for (int f = 0; f < RAY_FIELDS; f++) begin
                ops[f] <= '0;
            end
        end else begin
            m_start <= accept;
            if (accept) begin
                for (int f = 0; f < RAY_FIELDS; f++) begin
                    ops[f] <= sel_ray[f*W +: W];
                end
                rsp_id <= grant_idx;
                last   <= grant_idx;
                cnt    <= CW'(MARCH_CYCLES + 1);
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
            end

            if (flush) begin
                rsp_valid <= 1'b0;
            end else if (capture) begin
                rsp_valid     <= 1'b1;
                rsp_hit       <= m_hit;
                rsp_intensity <= m_intensity;
            end else if (handshake) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign m_origin_x = ops[ORG_X];
    assign m_origin_y = ops[ORG_Y];
    assign m_origin_z = ops[ORG_Z];
    assign m_dir_x    = ops[DIR_X];
    assign m_dir_y    = ops[DIR_Y];
    assign m_dir_z    = ops[DIR_Z];
    assign m_light_x  = ops[LIGHT_X];
    assign m_light_y  = ops[LIGHT_Y];
    assign m_light_z  = ops[LIGHT_Z];

endmodule

`default_nettype wire

// File: tb/tb_march_scheduler.sv
// ---------------------------------------------------------------------------
// tb_march_scheduler : directed table-driven bench for march_scheduler
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_march_scheduler;

    localparam int N_REQ = 2;
    localparam int W     = 16;
    localparam int MC    = 8;
    localparam int SW    = 9 * W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*SW-1:0]  req_ray;
    logic                 m_start;
    logic [W-1:0]         m_origin_x, m_origin_y, m_origin_z;
    logic [W-1:0]         m_dir_x, m_dir_y, m_dir_z;
    logic [W-1:0]         m_light_x, m_light_y, m_light_z;
    logic                 m_hit;
    logic [W-1:0]         m_intensity;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic                 rsp_hit;
    logic [W-1:0]         rsp_intensity;
    logic [SW-1:0]        m_all;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    march_scheduler #(
        .N_REQ        (N_REQ),
        .W            (W),
        .MARCH_CYCLES (MC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_ray       (req_ray),
        .m_start       (m_start),
        .m_origin_x    (m_origin_x),
        .m_origin_y    (m_origin_y),
        .m_origin_z    (m_origin_z),
        .m_dir_x       (m_dir_x),
        .m_dir_y       (m_dir_y),
        .m_dir_z       (m_dir_z),
        .m_light_x     (m_light_x),
        .m_light_y     (m_light_y),
        .m_light_z     (m_light_z),
        .m_hit         (m_hit),
        .m_intensity   (m_intensity),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_hit       (rsp_hit),
        .rsp_intensity (rsp_intensity)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign m_all = {m_light_z, m_light_y, m_light_x, m_dir_z, m_dir_y, m_dir_x,
                    m_origin_z, m_origin_y, m_origin_x};

    // Marcher model: result is only valid in the cycle before edge start+MC.
    logic          mdl_hit;
    logic [W-1:0]  mdl_int;
    int            mc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        mc <= 0;
        else if (m_start)  mc <= MC;
        else if (mc != 0)  mc <= mc - 1;
    end
    assign m_hit       = (mc == 1) ? mdl_hit : 1'b0;
    assign m_intensity = (mc == 1) ? mdl_int : 16'hDEAD;

    typedef struct {
        int          id;
        logic [SW-1:0] ray;
        logic        hit;
        logic [W-1:0] inten;
        logic [1:0]  exp_ready;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic run_job(input vec_t v);
        int n;
        req_ray = '0;
        req_ray[v.id*SW +: SW] = v.ray;
        mdl_hit   = v.hit;
        mdl_int   = v.inten;
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("vec_ready", req_ready, v.exp_ready);
        tick();
        req_valid = '0;
        check("vec_start_hi", m_start, 1);
        check("vec_operands", m_all, v.ray);
        tick();
        check("vec_start_lo", m_start, 0);
        wait_rsp(n);
        check("vec_latency", n + 1, MC + 1);
        check("vec_rsp_id", rsp_id, v.id);
        check("vec_rsp_hit", rsp_hit, v.hit);
        check("vec_rsp_int", rsp_intensity, v.inten);
        check("vec_operands_held", m_all, v.ray);
        tick();
        check("vec_rsp_drop", rsp_valid, 0);
    endtask

    logic [1:0] exp_rr [4];
    logic [SW-1:0] zero_ray;

    initial begin
        int n;
        int prev_cyc;

        vecs[0] = '{1, {16'h0, 16'h0, 16'h0, 16'h2D3F, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0100},
                    1'b1, 16'h1A00, 2'b10};
        vecs[1] = '{0, {16'h0909, 16'h0808, 16'h0707, 16'h0606, 16'h0505, 16'h0404,
                        16'h0303, 16'h0202, 16'h0101}, 1'b0, 16'h0000, 2'b01};
        vecs[2] = '{0, {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hABCD, 16'h1234,
                        16'hFFF0, 16'h0F0F, 16'hC3C3}, 1'b1, 16'h00FF, 2'b01};
        vecs[3] = '{1, {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666,
                        16'h7777, 16'h8888, 16'h9999}, 1'b0, 16'h7123, 2'b10};
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
        zero_ray = '0;

        rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_ray = '0;
        rsp_ready = 1'b0; mdl_hit = 1'b0; mdl_int = '0;
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_m_start", m_start, 0);
        check("rst_operands", m_all, zero_ray);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_hit, rsp_intensity}, 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            run_job(vecs[v]);
        end

        // Contention: both requesters continuously valid.
        req_ray = {vecs[3].ray, vecs[1].ray};
        mdl_hit = 1'b1; mdl_int = 16'h0042;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        prev_cyc = 0;
        #1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 40) begin
                tick();
                n++;
            end
            check($sformatf("rr_grant%0d", j), req_ready, exp_rr[j]);
            if (j > 0) check($sformatf("rr_spacing%0d", j), cyc - prev_cyc, MC + 3);
            prev_cyc = cyc;
            tick();
        end
        req_valid = '0;
        wait_rsp(n);
        tick();

        // Backpressure with requester 0 pending behind requester 1.
        rsp_ready = 1'b0; mdl_hit = 1'b0; mdl_int = 16'h7E57;
        req_valid = 2'b10;
        #1;
        check("bp_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b01;
        wait_rsp(n);
        check("bp_latency", n, MC + 1);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("bp_hold%0d", k),
                  {rsp_valid, rsp_id, rsp_hit, rsp_intensity, req_ready},
                  {1'b1, 1'b1, 1'b0, 16'h7E57, 2'b00});
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_handshake", {rsp_valid, req_ready}, {1'b0, 2'b01});
        tick();
        check("bp_next_start", m_start, 1);
        check("bp_next_id", rsp_id, 0);

        // Flush at cnt==5 of the job just accepted, with requester 1 pending.
        req_valid = 2'b10;
        for (int k = 0; k < 4; k++) tick();
        flush = 1'b1;
        #1;
        check("fl_ready_run", req_ready, 0);
        tick();
        check("fl_idle_gated", {rsp_valid, req_ready}, 0);
        flush = 1'b0;
        #1;
        check("fl_idle_ready", req_ready, 2'b10);
        mdl_hit = 1'b1; mdl_int = 16'h0C0C;
        tick();
        req_valid = '0;
        check("fl_accept_start", m_start, 1);
        wait_rsp(n);
        check("fl_no_stale_rsp", n, MC + 1);
        check("fl_rsp", {rsp_id, rsp_hit, rsp_intensity}, {1'b1, 1'b1, 16'h0C0C});
        tick();
        check("fl_rsp_drop", rsp_valid, 0);

        // Flush coinciding with a request in IDLE.
        req_valid = 2'b01; flush = 1'b1;
        #1;
        check("fl_req_ready", req_ready, 0);
        tick();
        check("fl_req_noaccept", m_start, 0);
        req_valid = '0; flush = 1'b0;
        tick();
        check("fl_req_noaccept_late", m_start, 0);

        // Flush coinciding with the response handshake.
        rsp_ready = 1'b0; mdl_hit = 1'b1; mdl_int = 16'h5A5A;
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        wait_rsp(n);
        rsp_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flh_drop", rsp_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("flh_no_dup%0d", k), {rsp_valid, req_ready}, 0);
        end

        // Async reset immediately after an accept.
        mdl_int = 16'h3333;
        req_ray = {vecs[3].ray, vecs[2].ray};
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        check("ar_pre_start", m_start, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_m_start", m_start, 0);
        check("ar_operands", m_all, zero_ray);
        check("ar_rsp", {rsp_valid, rsp_id, rsp_hit, rsp_intensity}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        check("ar_priority", req_ready, 2'b01);
        tick();
        req_valid = '0;
        check("ar_restart", m_start, 1);
        wait_rsp(n);
        check("ar_rsp_id", rsp_id, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/march_scheduler.md
# march_scheduler

Round-robin scheduler that shares one iterative ray/sphere marcher (`ray_sphere`) between `N_REQ` ray requesters, such as the primary-ray path of the sphere renderer and a secondary shadow/reflection path. It latches one requester's ray operands, pulses the marcher start, and holds the operands stable for the full march. It then samples hit/intensity at the fixed completion cycle and returns the result to the originating requester over a valid/ready handshake. A synchronous flush discards in-flight work at frame or scanline boundaries.

## Interface
- `N_REQ`, 2: number of requesters, ≥2.
- `W`, 16: signed operand width; also the intensity width.
- `MARCH_CYCLES`, 8: cycles from the marcher sampling `start` to valid `surface_hit`/`intensity`; ≥1.
- `clk` input 1: single clock; all logic rising-edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `flush` input 1: synchronous abort of the current job.
- `req_valid` input N_REQ: per-requester request valid.
- `req_ready` output N_REQ: one-hot grant/accept; at most one bit set.
- `req_ray` input N_REQ*9*W: per-requester packed operands. Requester i occupies slice [i*9*W +: 9*W]. Within the slice, fields run from LSB: origin x,y,z, dir x,y,z, light x,y,z.
- `m_start` output 1: marcher start pulse.
- `m_origin_x/y/z`, `m_dir_x/y/z`, `m_light_x/y/z` output W each: latched operands to the marcher.
- `m_hit` input 1; `m_intensity` input W: marcher results.
- `rsp_valid` output 1; `rsp_ready` input 1: response handshake.
- `rsp_id` output clog2(N_REQ): requester index of the response.
- `rsp_hit` output 1; `rsp_intensity` output W: captured results.

## Operation
- FSM states are IDLE, RUN and RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` is the combinational round-robin grant over `req_valid`, gated off when `flush`=1.
  - On an accept edge E0 (some `req_valid[i]` & `req_ready[i]`): latch slice i into the `m_*` operand registers, latch `rsp_id`<=i, set `last`<=i, load `cnt`<=MARCH_CYCLES+1, and go to RUN.
  - With no valid request, stay in IDLE. Operand registers keep their old values.
- Round-robin: search starts at `last`+1 mod N_REQ. `last` resets to N_REQ-1, so requester 0 wins first. A requester is never granted twice in a row while another requester is valid.
- RUN:
  - `cnt` decrements every edge.
  - When `cnt`==1 at an edge, capture `rsp_hit`<=`m_hit` and `rsp_intensity`<=`m_intensity`, set `rsp_valid`<=1, and go to RESP.
  - Operand registers are constant throughout RUN and RESP.
- RESP: hold `rsp_valid`, `rsp_id`, `rsp_hit` and `rsp_intensity` stable until `rsp_valid`&`rsp_ready` at an edge. Then clear `rsp_valid` and go to IDLE.
- `req_ready`=0 in RUN and RESP. There is no accept in the same cycle as a response handshake.
- `flush`=1 at an edge in any state: go to IDLE, clear `rsp_valid` and `m_start`, and produce no response. `cnt`, operands and `last` are don't-care/held. `flush` has priority over accept, capture and handshake in the same cycle.
- Async reset mid-job: everything returns to reset values immediately, and the job is lost.
- `cnt` width is clog2(MARCH_CYCLES+2). No other arithmetic; operands pass through unmodified.

## Timing
- Reset values: `req_ready`=0 (combinational; 0 when no request), `m_start`=0, all `m_*` operands 0, `rsp_valid`=0, `rsp_id`=0, `rsp_hit`=0, `rsp_intensity`=0.
- `m_start` is registered: high for exactly the one cycle following E0, and low otherwise.
- The marcher samples start at E0+1. Results are captured at edge E0+1+MARCH_CYCLES, so `rsp_valid` is high from that edge.
- Request-to-response latency is MARCH_CYCLES+1 edges after accept.
- Minimum job period is MARCH_CYCLES+3 cycles with `rsp_ready` held high (accept, MARCH_CYCLES+1 RUN edges, handshake, one IDLE cycle).
- `rsp_ready` low stalls indefinitely in RESP. Requesters wait; no request is dropped.

## Structure
- Package `march_pkg` holds:
  - state enum {IDLE, RUN, RESP};
  - field index constants for the 9-field ray slice (ORG_X=0 … LIGHT_Z=8);
  - `RAY_FIELDS`=9.
- Sub-module `rr_arbiter` (N_REQ parameter): inputs `req`, `last`, `en`; output one-hot `grant`. It is purely combinational; the FSM owns `last`.

## Test plan
- Single request, MARCH_CYCLES=8:
  - Stimulus: requester 1 presents origin x=0x0100 and dir z=0x2D3F; `rsp_ready`=1.
  - Response: `req_ready`=2'b10 at E0; `m_start` high at E0+1 only; operands stable. Marcher model returns hit=1, intensity=0x1A00. `rsp_valid` is high from E0+9 with `rsp_id`=1, hit=1, intensity=0x1A00, then IDLE at E0+10.
- Contention: both requesters held valid for 4 jobs, `rsp_ready`=1 -> grant order 0,1,0,1 and accepts spaced 11 cycles apart.
- Backpressure: `rsp_ready`=0 for 20 cycles after `rsp_valid` -> response fields unchanged, `req_ready` stays 0, and the next accept happens only after the handshake.
- Flush at the RUN midpoint (`cnt`=5) -> next cycle is IDLE, `rsp_valid` is never asserted, and a pending request is accepted the cycle after flush deasserts.
- Flush in the same cycle as `req_valid` in IDLE, and flush in the same cycle as the `rsp_ready` handshake -> no accept; `rsp_valid` drops and no duplicate response appears.
- Async reset asserted during RUN -> all outputs go to 0 immediately. After release, requester 0 has priority again (`last`=N_REQ-1).
